instruction_fetch: RTL
======================

# instruction_fetch

Instruction fetch sequencer sitting directly in front of `instruction_mem`: it owns the program counter, drives the memory's read address, captures the instruction word returned one cycle later, and hands it downstream through a 2-entry valid/ready buffer. It accounts for the memory's registered-address, 1-cycle read latency. It supports start, redirect (jump/branch) with flush of stale fetches, and stop. Throughput is one instruction per cycle under no backpressure.

## Interface
Parameters:
- `DATA_WIDTH`, 60, instruction word width; matches `instruction_mem`.
- `ADDR_WIDTH`, 8, instruction address width; matches `instruction_mem`.

Ports:
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `start` input 1: begin fetching at `start_addr`; honoured only in IDLE.
- `start_addr` input ADDR_WIDTH: first fetch address.
- `redirect_valid` input 1: jump/branch; honoured only in RUN.
- `redirect_addr` input ADDR_WIDTH: new fetch address.
- `stop` input 1: abort fetching, flush, return to IDLE.
- `mem_addr` output ADDR_WIDTH: to `instruction_mem.addr`; combinational from PC register.
- `mem_data` input DATA_WIDTH: from `instruction_mem.data_out`.
- `instr` output DATA_WIDTH: head instruction word.
- `instr_pc` output ADDR_WIDTH: address of `instr`.
- `instr_valid` output 1: `instr`/`instr_pc` valid.
- `instr_ready` input 1: downstream accepts the head this cycle.
- `busy` output 1: high in RUN.

## Operation
- States:
  - IDLE (reset state).
  - RUN.
- Transitions:
  - IDLE→RUN on `start`: `pc <= start_addr`.
  - RUN→IDLE on `stop`.
- Priority at an edge: `stop` > `redirect_valid` > normal fetch. `start` is ignored in RUN. `redirect_valid` and `stop` are ignored in IDLE.
- `mem_addr = pc` at all times. The memory latches it every edge, but only issued addresses are tracked.
- Issue condition: state is RUN, no `stop`/`redirect_valid` this cycle, and `occ + inflight - pop < 2`. Here `occ` is buffer occupancy (0..2), `inflight` is the issued-last-cycle flag, and `pop = instr_valid & instr_ready`.
- On issue at an edge:
  - `inflight <= 1`, `inflight_pc <= pc`.
  - `pc <= pc + 1`, modulo 2^ADDR_WIDTH, so 2^ADDR_WIDTH-1 wraps to 0 silently.
- With no issue at an edge: `inflight <= 0` and `pc` holds.
- Capture: if `inflight` is 1, then at the edge `{mem_data, inflight_pc}` is written to the buffer tail.
- Buffer:
  - FIFO order; the head drives `instr`, `instr_pc` and `instr_valid` from registers.
  - Pop and capture may occur on the same edge.
  - Overflow is impossible by the issue condition.
- Redirect:
  - Buffer flushed (occ←0), `inflight <= 0`, `pc <= redirect_addr`. State stays RUN.
  - A head popped in the same cycle counts as consumed.
  - Entries and in-flight data are discarded.
- Stop:
  - Same flush as redirect, and state goes to IDLE.
  - `pc` holds its value.
- `busy = (state == RUN)`.
- Reset values: state IDLE, `pc` 0 (so `mem_addr` 0), `inflight` 0, occ 0, `instr_valid` 0, `instr` 0, `instr_pc` 0, `busy` 0.
- Reset asserted mid-operation clears everything immediately. The buffer contents are lost.

## Timing
- Latency: `start` high in cycle 0 gives:
  - cycle 1: `mem_addr = start_addr` is issued;
  - cycle 2: `mem_data` is valid and captured;
  - cycle 3: `instr_valid = 1`, `instr_pc = start_addr`.
- Redirect in cycle k: first redirected instruction is presented in cycle k+3.
- Steady state with `instr_ready` = 1: one instruction per cycle with consecutive `instr_pc`.
- Backpressure (`instr_ready` = 0): at most 2 buffered plus 0 in flight, and issue halts. After `instr_ready` rises, there are no bubbles until the buffer drains; the next issue occurs the same cycle as the first pop.
- `instr`, `instr_pc` and `instr_valid` are stable while `instr_valid & ~instr_ready`.

## Test plan
- Stream: preload mem[i]=i+100. Pulse `start`, `start_addr` 5, hold ready=1 → valid from cycle 3, with `instr_pc` 5,6,7,… and `instr` 105,106,… every cycle.
- Backpressure: drop ready for 4 cycles mid-stream → occ saturates at 2 and `mem_addr` freezes. No instruction is lost or duplicated, and the sequence resumes gap-free.
- Redirect: while streaming at pc 10, assert `redirect_valid` with `redirect_addr` 40 for one cycle → no `instr_pc` in 11–13 appears after the flush. `instr_pc` 40 appears 3 cycles later, followed by 41, 42.
- Wrap: `start_addr` 254 → `instr_pc` sequence 254, 255, 0, 1.
- Stop and priority: assert `stop` and `redirect_valid` together → IDLE, `busy` 0, `instr_valid` 0 next cycle. A following `start` with `start_addr` 3 restarts cleanly.
- Reset mid-stream: pull `rst_n` low with 2 buffered → all outputs 0 asynchronously. After release, `busy` stays 0 until `start`.

Source files
------------

// File: rtl/instruction_fetch.sv
// Instruction fetch sequencer: owns the PC, drives a 1-cycle-latency instruction memory,
// and presents fetched words through a 2-entry valid/ready buffer with redirect and stop flush.
module instruction_fetch #(
    parameter int DATA_WIDTH = 60,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] start_addr,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_addr,
    input  logic                  stop,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_data,
    output logic [DATA_WIDTH-1:0] instr,
    output logic [ADDR_WIDTH-1:0] instr_pc,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    output logic                  busy
);

    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [ADDR_WIDTH-1:0] PC_ONE = ADDR_WIDTH'(1);

    state_t                state;
    logic [ADDR_WIDTH-1:0] pc;
    logic                  inflight;
    logic [ADDR_WIDTH-1:0] inflight_pc;
    logic [1:0]            occ;
    logic [DATA_WIDTH-1:0] tail_data;
    logic [ADDR_WIDTH-1:0] tail_pc;

    logic                  pop;
    logic [2:0]            pending;
    logic                  issue;
    logic [1:0]            occ_after_pop;
    logic [1:0]            occ_next;

    assign mem_addr = pc;
    assign busy     = (state == RUN);
    assign pop      = instr_valid & instr_ready;

    // Words already committed to the buffer after this edge; issue only while a slot remains.
    assign pending       = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
    assign issue         = (state == RUN) && !stop && !redirect_valid && (pending < 3'd2);
    assign occ_after_pop = occ - {1'b0, pop};
    assign occ_next      = occ_after_pop + {1'b0, inflight};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            pc          <= '0;
            inflight    <= 1'b0;
            inflight_pc <= '0;
            occ         <= '0;
            instr       <= '0;
            instr_pc    <= '0;
            instr_valid <= 1'b0;
            tail_data   <= '0;
            tail_pc     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    inflight <= 1'b0;
                    if (start) begin
                        state <= RUN;
                        pc    <= start_addr;
                    end
                end
                RUN: begin
                    if (stop || redirect_valid) begin
                        inflight    <= 1'b0;
                        occ         <= '0;
                        instr_valid <= 1'b0;
                        if (stop) begin
                            state <= IDLE;
                        end else begin
                            pc <= redirect_addr;
                        end
                    end else begin
                        inflight <= issue;
                        if (issue) begin
                            inflight_pc <= pc;
                            pc          <= pc + PC_ONE;
                        end
                        if (pop) begin
                            instr    <= tail_data;
                            instr_pc <= tail_pc;
                        end
                        // A capture lands at the first free slot after the pop; this overrides the shift.
                        if (inflight) begin
                            if (occ_after_pop == 2'd0) begin
                                instr    <= mem_data;
                                instr_pc <= inflight_pc;
                            end else begin
                                tail_data <= mem_data;
                                tail_pc   <= inflight_pc;
                            end
                        end
                        occ         <= occ_next;
                        instr_valid <= (occ_next != 2'd0);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
